// File: rtl/reset_sequencer.sv
// Sequenced reset generator: async assert, synchronised release, minimum assertion window,
// then in-order per-channel release with programmable gaps, per-channel holds and soft reset.
module reset_sequencer #(
    parameter int SYNC_STAGES = 3,
    parameter int NUM_OUT     = 4,
    parameter int DELAY_W     = 8,
    parameter int MIN_ASSERT  = 16
) (
    input  logic                         clk,
    input  logic                         resn_in,
    input  logic                         soft_rst_req,
    input  logic [NUM_OUT-1:0]           hold,
    input  logic [NUM_OUT*DELAY_W-1:0]   stage_delay,
    output logic [NUM_OUT-1:0]           resn_out,
    output logic                         done
);

    localparam int MA_W  = (MIN_ASSERT > 1) ? $clog2(MIN_ASSERT) : 1;
    localparam int CNT_W = (DELAY_W > MA_W) ? DELAY_W : MA_W;
    localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MIN_ASSERT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_OUT - 1);

    typedef enum logic [1:0] {
        S_WAIT_SYNC,
        S_HOLD,
        S_SEQ,
        S_DONE
    } state_t;

    (* ASYNC_REG = "TRUE", IOB = "FALSE" *)
    logic [SYNC_STAGES-1:0]       sync_q;
    logic                         sync_ok;

    state_t                       state_q, state_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [NUM_OUT-1:0]           resn_out_q, resn_out_d;
    logic                         done_q, done_d;
    logic [NUM_OUT*DELAY_W-1:0]   dly_q, dly_d;
    logic [CNT_W-1:0]             cur_dly;

    // Only the deassertion edge passes through the chain; assertion is immediate.
    always_ff @(posedge clk or negedge resn_in) begin
        if (!resn_in) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = sync_q[SYNC_STAGES-1];
    assign cur_dly = CNT_W'(dly_q[idx_q*DELAY_W +: DELAY_W]);

    always_ff @(posedge clk or negedge resn_in) begin
        if (!resn_in) begin
            state_q    <= S_WAIT_SYNC;
            cnt_q      <= '0;
            idx_q      <= '0;
            resn_out_q <= '0;
            done_q     <= 1'b0;
            dly_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            resn_out_q <= resn_out_d;
            done_q     <= done_d;
            dly_q      <= dly_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        resn_out_d = resn_out_q;
        done_d     = done_q;
        dly_d      = dly_q;

        case (state_q)
            S_WAIT_SYNC: begin
                if (sync_ok) begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_SEQ;
                    cnt_d   = '0;
                    idx_d   = '0;
                    dly_d   = stage_delay;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SEQ: begin
                // A held channel freezes the whole sequence so release order is preserved.
                if (!hold[idx_q]) begin
                    if (cnt_q == cur_dly) begin
                        resn_out_d[idx_q] = 1'b1;
                        cnt_d             = '0;
                        if (idx_q == LAST_IDX) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                resn_out_d = '1;
                done_d     = 1'b1;
            end
            default: begin
                state_d = S_WAIT_SYNC;
            end
        endcase

        // Soft reset outranks any release scheduled for the same edge.
        if (soft_rst_req && (state_q != S_WAIT_SYNC)) begin
            state_d    = S_HOLD;
            cnt_d      = '0;
            idx_d      = '0;
            resn_out_d = '0;
            done_d     = 1'b0;
        end
    end

    assign resn_out = resn_out_q;
    assign done     = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: release timing, gaps, holds, soft and hard reset, small-parameter sweep.
module tb_reset_sequencer;

    logic        clk;
    logic        resn_in;
    logic        soft_rst_req;
    logic [3:0]  hold;
    logic [31:0] stage_delay;
    logic [3:0]  resn_out;
    logic        done;

    logic        sw_resn;
    logic        sw_soft;
    logic [0:0]  sw_hold;
    logic [7:0]  sw_dly;
    logic [0:0]  sw_out;
    logic        sw_done;

    reset_sequencer #(
        .SYNC_STAGES(3), .NUM_OUT(4), .DELAY_W(8), .MIN_ASSERT(16)
    ) u_dut (
        .clk(clk), .resn_in(resn_in), .soft_rst_req(soft_rst_req), .hold(hold),
        .stage_delay(stage_delay), .resn_out(resn_out), .done(done)
    );

    reset_sequencer #(
        .SYNC_STAGES(2), .NUM_OUT(1), .DELAY_W(8), .MIN_ASSERT(1)
    ) u_sw (
        .clk(clk), .resn_in(sw_resn), .soft_rst_req(sw_soft), .hold(sw_hold),
        .stage_delay(sw_dly), .resn_out(sw_out), .done(sw_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int e;
    int rise_e[4];
    int done_e;
    logic [4:0] snap[0:127];
    bit thermo_bad;
    bit hold_leak;

    int hon, hoff, s1, s2, chg_e, hr_e;
    logic [31:0] chg_val;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic hard_restart();
        resn_in = 1'b0;
        @(negedge clk);
        resn_in = 1'b1;
        e = 0;
    endtask

    task automatic clear_marks();
        for (int i = 0; i < 4; i++) rise_e[i] = -1;
        done_e = -1;
        for (int i = 0; i < 128; i++) snap[i] = 5'h1f;
    endtask

    task automatic run(input int max);
        logic [3:0] prev;
        logic       pd;
        prev = resn_out;
        pd   = done;
        clear_marks();
        thermo_bad = 1'b0;
        hold_leak  = 1'b0;
        for (int k = 0; k < max; k++) begin
            soft_rst_req = ((e + 1) == s1) || ((e + 1) == s2);
            hold[1]      = (hon > 0) && ((e + 1) >= hon) && ((e + 1) <= hoff);
            if (chg_e > 0 && e == chg_e) stage_delay = chg_val;
            @(posedge clk);
            e++;
            #1;
            if (e < 128) snap[e] = {done, resn_out};
            for (int i = 0; i < 4; i++)
                if (resn_out[i] && !prev[i] && rise_e[i] < 0) rise_e[i] = e;
            if (done && !pd && done_e < 0) done_e = e;
            if ((resn_out & (resn_out + 4'd1)) != 4'd0) thermo_bad = 1'b1;
            if (hold[1] && (resn_out[3:1] != 3'b000)) hold_leak = 1'b1;
            prev = resn_out;
            pd   = done;
            if (hr_e > 0 && e == hr_e) begin
                hr_e    = 0;
                resn_in = 1'b0;
                #1;
                chk("hard_async_clear", {27'd0, done, resn_out}, 32'd0);
                resn_in = 1'b1;
                e       = 0;
                clear_marks();
                prev = resn_out;
                pd   = done;
            end
        end
        soft_rst_req = 1'b0;
        hold         = 4'b0000;
    endtask

    task automatic chk_rel(input string tag, input int r0, input int r1, input int r2,
                           input int r3, input int d);
        chk({tag, "_ch0"}, rise_e[0], r0);
        chk({tag, "_ch1"}, rise_e[1], r1);
        chk({tag, "_ch2"}, rise_e[2], r2);
        chk({tag, "_ch3"}, rise_e[3], r3);
        chk({tag, "_done"}, done_e, d);
        chk({tag, "_thermo"}, {31'd0, thermo_bad}, 32'd0);
    endtask

    initial begin
        int sw_rise;
        int sw_done_e;
        resn_in      = 1'b1;
        soft_rst_req = 1'b0;
        hold         = 4'b0000;
        stage_delay  = {4{8'd2}};
        sw_resn      = 1'b1;
        sw_soft      = 1'b0;
        sw_hold      = 1'b0;
        sw_dly       = 8'd0;
        hon = 0; hoff = 0; s1 = 0; s2 = 0; chg_e = 0; hr_e = 0; chg_val = '0;
        e = 0;

        #2;
        resn_in = 1'b0;
        sw_resn = 1'b0;
        #1;
        chk("reset_resn_out", {28'd0, resn_out}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_held_out", {27'd0, done, resn_out}, 32'd0);

        // Power-up, all gaps 2
        hard_restart();
        run(40);
        chk_rel("pwrup", 23, 26, 29, 32, 32);

        // Mixed gaps {ch3..ch0} = {3,0,5,1}
        stage_delay = {8'd3, 8'd0, 8'd5, 8'd1};
        hard_restart();
        run(40);
        chk_rel("mixed", 22, 28, 29, 33, 33);

        // hold[1] sampled high on edges 10..40
        stage_delay = {4{8'd2}};
        hon = 10; hoff = 40;
        hard_restart();
        run(60);
        hon = 0; hoff = 0;
        chk_rel("hold", 23, 43, 46, 49, 49);
        chk("hold_leak", {31'd0, hold_leak}, 32'd0);

        // Soft reset pulse in DONE on edge 1
        e = 0; s1 = 1;
        run(40);
        chk("soft_clear", {27'd0, snap[1]}, 32'd0);
        chk_rel("soft", 20, 23, 26, 29, 29);

        // Soft reset at edge 1 and again in HOLD at edge 6; delays changed after capture
        e = 0; s1 = 1; s2 = 6; chg_e = 23; chg_val = {4{8'd9}};
        run(45);
        s1 = 0; s2 = 0; chg_e = 0;
        chk_rel("soft2", 25, 28, 31, 34, 34);

        // Sub-cycle hard reset while idx=2, then full sequence again
        stage_delay = {4{8'd2}};
        hard_restart();
        hr_e = 27;
        run(70);
        chk_rel("hardmid", 23, 26, 29, 32, 32);

        // Small-parameter instance; soft request held through WAIT_SYNC
        sw_rise   = -1;
        sw_done_e = -1;
        sw_soft   = 1'b1;
        @(negedge clk);
        sw_resn = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (sw_out[0] && sw_rise < 0) sw_rise = k;
            if (sw_done && sw_done_e < 0) sw_done_e = k;
            if (k == 3) sw_soft = 1'b0;
        end
        chk("sweep_rise", sw_rise, 5);
        chk("sweep_done", sw_done_e, 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
